// File: rtl/gate_identifier.sv
// Sweeps the four {a,b} input vectors through a 2-input gate, samples its response and decodes the truth table.
// Optional macro GATE_ID_REPEAT_EN: sweep twice and flag a pass-to-pass mismatch on `unstable`.
module gate_identifier #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter int unsigned CNT_W         = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       resp,
  output logic       stim_a,
  output logic       stim_b,
  output logic       busy,
  output logic       done,
  output logic [3:0] truth_table,
  output logic [3:0] gate_code,
  output logic       valid_gate,
  output logic       unstable
);

`ifdef GATE_ID_REPEAT_EN
  localparam int unsigned NUM_VEC = 8;
`else
  localparam int unsigned NUM_VEC = 4;
`endif
  localparam int unsigned IDX_W = $clog2(NUM_VEC);
  localparam logic [CNT_W-1:0] SETTLE_MAX = CNT_W'(SETTLE_CYCLES);
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(NUM_VEC - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    DONE
  } state_e;

  function automatic logic [3:0] decode(input logic [3:0] tt);
    logic [3:0] code;
    case (tt)
      4'h8:    code = 4'd1;   // AND
      4'hE:    code = 4'd2;   // OR
      4'h7:    code = 4'd3;   // NAND
      4'h1:    code = 4'd4;   // NOR
      4'h6:    code = 4'd5;   // XOR
      4'h9:    code = 4'd6;   // XNOR
      4'h3:    code = 4'd7;   // NOT_A
      4'h5:    code = 4'd8;   // NOT_B
      4'hC:    code = 4'd9;   // BUF_A
      4'hA:    code = 4'd10;  // BUF_B
      4'h0:    code = 4'd11;  // CONST0
      4'hF:    code = 4'd12;  // CONST1
      default: code = 4'd0;   // UNKNOWN
    endcase
    return code;
  endfunction

  state_e           state_q, state_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [3:0]       pass1_q, pass1_d;
  logic [1:0]       stim_q, stim_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [3:0]       tt_q, tt_d;
  logic [3:0]       code_q, code_d;
  logic             valid_q, valid_d;
`ifdef GATE_ID_REPEAT_EN
  logic [3:0]       pass2_q, pass2_d;
  logic             unstable_q, unstable_d;
`endif

  // NOTE: every signal assigned below gets a default first, so no path can leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    pass1_d = pass1_q;
    stim_d  = 2'b00;
    busy_d  = 1'b0;
    done_d  = 1'b0;
    tt_d    = tt_q;
    code_d  = code_q;
    valid_d = valid_q;
`ifdef GATE_ID_REPEAT_EN
    pass2_d    = pass2_q;
    unstable_d = unstable_q;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = DRIVE;
          idx_d   = '0;
          cnt_d   = '0;
          busy_d  = 1'b1;
        end
      end

      DRIVE: begin
        busy_d = 1'b1;
        stim_d = idx_q[1:0];
        if (cnt_q == SETTLE_MAX) begin
          // Last hold cycle of this vector: capture resp and move on.
          cnt_d = '0;
`ifdef GATE_ID_REPEAT_EN
          if (idx_q[2]) pass2_d[idx_q[1:0]] = resp;
          else          pass1_d[idx_q[1:0]] = resp;
`else
          pass1_d[idx_q[1:0]] = resp;
`endif
          if (idx_q == LAST_IDX) begin
            state_d = DONE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            stim_d  = 2'b00;
            tt_d    = pass1_d;
`ifdef GATE_ID_REPEAT_EN
            unstable_d = (pass2_d != pass1_d);
            code_d     = unstable_d ? 4'd0 : decode(pass1_d);
`else
            code_d     = decode(pass1_d);
`endif
            valid_d = (code_d >= 4'd1) && (code_d <= 4'd8);
          end else begin
            idx_d  = idx_q + IDX_W'(1);
            stim_d = idx_d[1:0];
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      DONE: state_d = IDLE;

      default: state_d = IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments only; the shadow bits are reset too so a fresh sweep never sees stale samples.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      pass1_q <= '0;
      stim_q  <= 2'b00;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      tt_q    <= '0;
      code_q  <= '0;
      valid_q <= 1'b0;
`ifdef GATE_ID_REPEAT_EN
      pass2_q    <= '0;
      unstable_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      pass1_q <= pass1_d;
      stim_q  <= stim_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      tt_q    <= tt_d;
      code_q  <= code_d;
      valid_q <= valid_d;
`ifdef GATE_ID_REPEAT_EN
      pass2_q    <= pass2_d;
      unstable_q <= unstable_d;
`endif
    end
  end

  assign stim_a      = stim_q[1];
  assign stim_b      = stim_q[0];
  assign busy        = busy_q;
  assign done        = done_q;
  assign truth_table = tt_q;
  assign gate_code   = code_q;
  assign valid_gate  = valid_q;
`ifdef GATE_ID_REPEAT_EN
  assign unstable    = unstable_q;
`else
  assign unstable    = 1'b0;
`endif

endmodule
